// File: rtl/roman_scroll_disp.sv
// roman_scroll_disp: converts 0..89 to a Roman symbol string one symbol per cycle,
// then scans (and scrolls, if too long) it over a multiplexed 7-segment bank.
module roman_scroll_disp #(
   parameter int VAL_WIDTH   = 7,
   parameter int NUM_DIGITS  = 4,
   parameter int SEG_WIDTH   = 7,
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 25000000,
   parameter int MAX_SYM     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [VAL_WIDTH-1:0]  in,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  err,
   output logic [SEG_WIDTH-1:0]  seg_out,
   output logic [NUM_DIGITS-1:0] an_out
);
   typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
   localparam int LW = $clog2(MAX_SYM + 1);
   localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
   localparam int KW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(MAX_SYM + NUM_DIGITS + 1) + 1;
   localparam logic [2:0] C_NUL = 3'd0, C_I = 3'd1, C_V = 3'd2, C_X = 3'd3, C_L = 3'd4;

   state_t                state_q, state_d;
   logic [VAL_WIDTH-1:0]  rem_q, rem_d, sub;
   logic [2:0]            pend_q, pend_d, sym, dsym;
   logic [2:0]            sbuf_q [MAX_SYM];
   logic [2:0]            sbuf_d [MAX_SYM];
   logic [LW-1:0]         len_q, len_d, off_q, off_d;
   logic                  err_q, err_d, accept;
   logic [RW-1:0]         ref_q, ref_d;
   logic [SW-1:0]         scr_q, scr_d;
   logic [KW-1:0]         k_q, k_d;
   logic [PW-1:0]         pos, p;
   logic [SEG_WIDTH-1:0]  seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   function automatic logic [SEG_WIDTH-1:0] image(input logic [2:0] s);
      image = s == C_I ? SEG_WIDTH'(7'b1111001) :
              s == C_V ? SEG_WIDTH'(7'b1000001) :
              s == C_X ? SEG_WIDTH'(7'b0001001) :
              s == C_L ? SEG_WIDTH'(7'b1000111) : SEG_WIDTH'(7'b1111111);
   endfunction

   assign in_ready = state_q != CONVERT;
   assign busy     = state_q == CONVERT;
   assign err      = err_q;
   assign seg_out  = seg_q;
   assign an_out   = an_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      pend_d  = pend_q;
      sbuf_d  = sbuf_q;
      len_d   = len_q;
      off_d   = off_q;
      err_d   = err_q;
      ref_d   = ref_q;
      scr_d   = scr_q;
      k_d     = k_q;
      sym     = C_NUL;
      sub     = '0;
      accept  = in_valid && in_ready;
      if (state_q != IDLE) begin
         ref_d = ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + 1'b1;
         if (ref_q == RW'(REFRESH_DIV - 1)) k_d = k_q == KW'(NUM_DIGITS - 1) ? '0 : k_q + 1'b1;
      end
      if (state_q == CONVERT) begin
         // Pairs (XL, IX, IV) emit their first symbol now and park the second in pend_q
         if (rem_q > VAL_WIDTH'(89)) err_d = 1'b1;
         else if (pend_q != C_NUL) begin
            sym    = pend_q;
            sub    = pend_q == C_L ? VAL_WIDTH'(40) : pend_q == C_X ? VAL_WIDTH'(9) : VAL_WIDTH'(4);
            pend_d = C_NUL;
         end
         else if (rem_q >= VAL_WIDTH'(50)) begin sym = C_L; sub = VAL_WIDTH'(50); end
         else if (rem_q >= VAL_WIDTH'(40)) begin sym = C_X; pend_d = C_L; end
         else if (rem_q >= VAL_WIDTH'(10)) begin sym = C_X; sub = VAL_WIDTH'(10); end
         else if (rem_q >= VAL_WIDTH'(9))  begin sym = C_I; pend_d = C_X; end
         else if (rem_q >= VAL_WIDTH'(5))  begin sym = C_V; sub = VAL_WIDTH'(5); end
         else if (rem_q >= VAL_WIDTH'(4))  begin sym = C_I; pend_d = C_V; end
         else if (rem_q >= VAL_WIDTH'(1))  begin sym = C_I; sub = VAL_WIDTH'(1); end
         if (sym != C_NUL) begin
            for (int i = 0; i < MAX_SYM; i++) if (len_q == LW'(i)) sbuf_d[i] = sym;
            len_d = len_q + 1'b1;
         end
         rem_d = rem_q - sub;
         if (err_d || rem_d == '0) state_d = SHOW;
      end
      if (state_q == SHOW && int'(len_q) > NUM_DIGITS) begin
         scr_d = scr_q == SW'(SCROLL_DIV - 1) ? '0 : scr_q + 1'b1;
         if (scr_q == SW'(SCROLL_DIV - 1)) off_d = off_q == len_q ? '0 : off_q + 1'b1;
      end
      if (accept) begin
         state_d = CONVERT;
         rem_d   = in;
         pend_d  = C_NUL;
         for (int i = 0; i < MAX_SYM; i++) sbuf_d[i] = C_NUL;
         len_d   = '0;
         off_d   = '0;
         scr_d   = '0;
         err_d   = 1'b0;
      end
   end

   always_comb begin
      // Scrolling windows wrap over len+1 slots; slot len is the blank gap
      pos  = PW'(off_q) + PW'(k_q);
      p    = (int'(len_q) > NUM_DIGITS && pos > PW'(len_q)) ? pos - PW'(len_q) - 1'b1 : pos;
      dsym = C_NUL;
      for (int i = 0; i < MAX_SYM; i++) if (p == PW'(i) && LW'(i) < len_q) dsym = sbuf_q[i];
      seg_d = state_q == SHOW ? image(dsym) : image(C_NUL);
      an_d  = state_q == IDLE ? '1 : ~(NUM_DIGITS'(1) << k_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         pend_q  <= C_NUL;
         for (int i = 0; i < MAX_SYM; i++) sbuf_q[i] <= C_NUL;
         len_q   <= '0;
         off_q   <= '0;
         err_q   <= 1'b0;
         ref_q   <= '0;
         scr_q   <= '0;
         k_q     <= '0;
         seg_q   <= image(C_NUL);
         an_q    <= '1;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         pend_q  <= pend_d;
         sbuf_q  <= sbuf_d;
         len_q   <= len_d;
         off_q   <= off_d;
         err_q   <= err_d;
         ref_q   <= ref_d;
         scr_q   <= scr_d;
         k_q     <= k_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end
endmodule
